// File: rtl/ex_seq_pkg.sv
// ex_seq_pkg: shared definitions for the EX-stage sequencer.
//   state_t    : sequencer FSM states
//   op_class_t : operation class produced by ex_seq_decode
//   FN_*       : ALU funct encodings
//   first_state: first FSM state an accepted op of a given class enters
package ex_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXEC,
        ST_WB,
        ST_JUMP
    } state_t;

    typedef enum logic [1:0] {
        CLS_TWO,    // two-operand ALU op: load accumulator first
        CLS_ONE,    // single-operand ALU op: straight to compute
        CLS_JUMP    // j or jc: resolve branch only
    } op_class_t;

    localparam logic [2:0] FN_ADD  = 3'b000;
    localparam logic [2:0] FN_SUB  = 3'b001;
    localparam logic [2:0] FN_AND  = 3'b010;
    localparam logic [2:0] FN_OR   = 3'b011;
    localparam logic [2:0] FN_NOT  = 3'b100;
    localparam logic [2:0] FN_SHL  = 3'b101;
    localparam logic [2:0] FN_SHR  = 3'b110;
    localparam logic [2:0] FN_PASS = 3'b111;

    function automatic state_t first_state(input op_class_t cls);
        case (cls)
            CLS_TWO:  return ST_LOAD;
            CLS_ONE:  return ST_EXEC;
            CLS_JUMP: return ST_JUMP;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ex_seq_decode.sv
// ex_seq_decode: combinational op-class decoder, shared with hazard logic.
//   funct  in  3 : ALU operation code
//   j      in  1 : unconditional jump
//   jc     in  1 : conditional jump
//   op_cls out 2 : operation class (jump takes precedence over funct)
module ex_seq_decode
    import ex_seq_pkg::*;
(
    input  logic [2:0] funct,
    input  logic       j,
    input  logic       jc,
    output op_class_t  op_cls
);

    always_comb begin
        op_cls = CLS_TWO;
        if (j | jc)
            op_cls = CLS_JUMP;
        else if (funct[2])
            op_cls = CLS_ONE;
    end

endmodule

// File: rtl/ex_sequencer.sv
// ex_sequencer: multi-cycle controller for the EX accumulator datapath.
// Walks one decoded op through LOAD -> EXEC -> WB, or resolves a jump,
// issuing one-cycle strobes and stalling upstream while in flight.
//   clock, reset (sync, active-high)
//   start, funct, ina, sout, j, jc, neq : decoded op from ID/EX
//   zero_in                              : current zero register value
//   ac_load, mux_sel                     : input accumulator control
//   alu_op, alu_en                       : ALU control
//   out_capture                          : output accumulator / zero reg strobe
//   jump_calc, taken                     : branch resolution
//   busy, stall, done                    : pipeline handshake
module ex_sequencer
    import ex_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] funct,
    input  logic       ina,
    input  logic       sout,
    input  logic       j,
    input  logic       jc,
    input  logic       neq,
    input  logic       zero_in,
    output logic       ac_load,
    output logic       mux_sel,
    output logic [2:0] alu_op,
    output logic       alu_en,
    output logic       out_capture,
    output logic       jump_calc,
    output logic       taken,
    output logic       busy,
    output logic       stall,
    output logic       done
);

    // A sign-extended immediate needs at least a sign bit and one value bit.
    if (W < 2) begin : g_width_check
        $error("ex_sequencer: W must be at least 2");
    end

    state_t    state;
    state_t    next_state;
    op_class_t op_cls;
    logic      accept;

    logic [2:0] funct_q;
    logic       ina_q;
    logic       sout_q;
    logic       j_q;
    logic       jc_q;
    logic       neq_q;

    ex_seq_decode u_decode (
        .funct  (funct),
        .j      (j),
        .jc     (jc),
        .op_cls (op_cls)
    );

    // New ops are taken in IDLE and in the final cycle of an op, so
    // back-to-back ops run without a bubble.
    always_comb begin
        accept     = start & ((state == ST_IDLE) | (state == ST_WB) | (state == ST_JUMP));
        next_state = state;
        case (state)
            ST_IDLE, ST_WB, ST_JUMP: next_state = accept ? first_state(op_cls) : ST_IDLE;
            ST_LOAD:                 next_state = ST_EXEC;
            ST_EXEC:                 next_state = ST_WB;
            default:                 next_state = ST_IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with the
    // state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            funct_q     <= '0;
            ina_q       <= 1'b0;
            sout_q      <= 1'b0;
            j_q         <= 1'b0;
            jc_q        <= 1'b0;
            neq_q       <= 1'b0;
            ac_load     <= 1'b0;
            alu_en      <= 1'b0;
            out_capture <= 1'b0;
            jump_calc   <= 1'b0;
            busy        <= 1'b0;
            stall       <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                funct_q <= funct;
                ina_q   <= ina;
                sout_q  <= sout;
                j_q     <= j;
                jc_q    <= jc;
                neq_q   <= neq;
            end
            ac_load     <= (next_state == ST_LOAD);
            alu_en      <= (next_state == ST_EXEC);
            out_capture <= (next_state == ST_WB) & sout_q;
            jump_calc   <= (next_state == ST_JUMP);
            busy        <= (next_state != ST_IDLE);
            stall       <= (next_state == ST_LOAD) | (next_state == ST_EXEC);
            done        <= (next_state == ST_WB) | (next_state == ST_JUMP);
        end
    end

    assign mux_sel = ina_q;
    assign alu_op  = funct_q;
    // zero_in is the live zero register value during the JUMP cycle.
    assign taken   = jump_calc & (j_q | (jc_q & (zero_in ^ neq_q)));

endmodule

// File: tb/tb_ex_sequencer.sv
// tb_ex_sequencer: scoreboard bench for ex_sequencer. Expected output
// vectors are queued with their target cycle when stimulus is driven and
// compared on the falling edge of that cycle.
module tb_ex_sequencer;
    import ex_seq_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] funct = '0;
    logic       ina = 1'b0;
    logic       sout = 1'b0;
    logic       j = 1'b0;
    logic       jc = 1'b0;
    logic       neq = 1'b0;
    logic       zero_in = 1'b0;
    logic       ac_load, mux_sel, alu_en, out_capture, jump_calc, taken, busy, stall, done;
    logic [2:0] alu_op;

    ex_sequencer #(.W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .funct       (funct),
        .ina         (ina),
        .sout        (sout),
        .j           (j),
        .jc          (jc),
        .neq         (neq),
        .zero_in     (zero_in),
        .ac_load     (ac_load),
        .mux_sel     (mux_sel),
        .alu_op      (alu_op),
        .alu_en      (alu_en),
        .out_capture (out_capture),
        .jump_calc   (jump_calc),
        .taken       (taken),
        .busy        (busy),
        .stall       (stall),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Packed view: {ac_load, mux_sel, alu_op[2:0], alu_en, out_capture,
    //               jump_calc, taken, busy, stall, done}
    localparam logic [11:0] M_AC   = 12'h800;
    localparam logic [11:0] M_MUX  = 12'h400;
    localparam logic [11:0] M_OP   = 12'h380;
    localparam logic [11:0] M_EN   = 12'h040;
    localparam logic [11:0] M_OC   = 12'h020;
    localparam logic [11:0] M_JC   = 12'h010;
    localparam logic [11:0] M_TK   = 12'h008;
    localparam logic [11:0] M_BUSY = 12'h004;
    localparam logic [11:0] M_ST   = 12'h002;
    localparam logic [11:0] M_DONE = 12'h001;
    localparam logic [11:0] M_ALL  = 12'hFFF;

    logic [11:0] obs;
    assign obs = {ac_load, mux_sel, alu_op, alu_en, out_capture,
                  jump_calc, taken, busy, stall, done};

    function automatic logic [11:0] op_bits(input logic [2:0] f);
        return {2'b00, f, 7'b0};
    endfunction

    typedef struct {
        int          cyc;
        string       tag;
        logic [11:0] exp;
        logic [11:0] mask;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc = 0;
    int        n_checks = 0;
    int        n_passed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
        n_checks++;
        if (got === want)
            n_passed++;
        else
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, want);
    endtask

    task automatic expect_at(input int c, input string tag,
                             input logic [11:0] e, input logic [11:0] m);
        sb_entry_t s;
        s.cyc = c; s.tag = tag; s.exp = e; s.mask = m;
        sb.push_back(s);
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_entry_t s;
            s = sb.pop_front();
            if (s.cyc < cyc)
                check({s.tag, "_late"}, 12'(cyc), 12'(s.cyc));
            else
                check(s.tag, obs & s.mask, s.exp & s.mask);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_op(input logic [2:0] f, input logic a, input logic s,
                          input logic jj, input logic jjc, input logic nq);
        start = 1'b1; funct = f; ina = a; sout = s; j = jj; jc = jjc; neq = nq;
    endtask

    task automatic clear_op();
        start = 1'b0; funct = '0; ina = 1'b0; sout = 1'b0; j = 1'b0; jc = 1'b0; neq = 1'b0;
    endtask

    task automatic jump_case(input string tag, input logic zin, input logic nq,
                             input logic exp_taken);
        int c0;
        c0 = cyc;
        set_op(FN_ADD, 1'b0, 1'b0, 1'b0, 1'b1, nq);
        zero_in = zin;
        expect_at(c0 + 1, tag, M_JC | M_BUSY | M_DONE | (exp_taken ? M_TK : 12'h000),
                  M_JC | M_TK | M_DONE | M_ST | M_BUSY | M_EN | M_OC | M_AC);
        tick(1);
        clear_op();
        tick(1);
        zero_in = 1'b0;
        tick(1);
    endtask

    initial begin
        int c0;
        logic [11:0] e;

        // Reset with start also high: reset wins, everything stays 0.
        set_op(FN_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(1, "reset_c1", 12'h000, M_ALL);
        expect_at(2, "reset_with_start", 12'h000, M_ALL);
        for (int k = 4; k <= 8; k++)
            expect_at(k, $sformatf("idle_c%0d", k - 3), 12'h000, M_ALL);
        tick(3);
        reset = 1'b0;
        clear_op();
        tick(6);

        // Two-operand SUB with immediate and write-back.
        c0 = cyc;
        set_op(FN_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(c0 + 1, "two_load", M_AC | M_MUX | M_BUSY | M_ST,
                  M_AC | M_MUX | M_EN | M_BUSY | M_ST | M_DONE);
        expect_at(c0 + 2, "two_exec", op_bits(FN_SUB) | M_EN | M_ST,
                  M_OP | M_EN | M_AC | M_ST | M_DONE | M_OC);
        expect_at(c0 + 3, "two_wb", op_bits(FN_SUB) | M_OC | M_DONE,
                  M_OP | M_EN | M_OC | M_ST | M_DONE);
        expect_at(c0 + 4, "two_idle", 12'h000, M_BUSY | M_ST | M_DONE);
        tick(1);
        clear_op();
        tick(4);

        // Conditional jumps.
        jump_case("jc_z1_neq0", 1'b1, 1'b0, 1'b1);
        jump_case("jc_z0_neq0", 1'b0, 1'b0, 1'b0);
        jump_case("jc_z0_neq1", 1'b0, 1'b1, 1'b1);

        // Back-to-back NOT, ADD, j with start held high.
        c0 = cyc;
        set_op(FN_NOT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            e = 12'h000;
            if (k == 2 || k == 5 || k == 6) e |= M_DONE;
            if (k == 2 || k == 5)           e |= M_OC;
            if (k == 1 || k == 4)           e |= M_EN;
            if (k == 3)                     e |= M_AC;
            if (k == 6)                     e |= M_JC | M_TK;
            if (k <= 6)                     e |= M_BUSY;
            expect_at(c0 + k, $sformatf("b2b_c%0d", k), e,
                      M_AC | M_EN | M_OC | M_JC | M_TK | M_BUSY | M_DONE);
        end
        tick(2);
        set_op(FN_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        set_op(FN_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        clear_op();
        tick(3);

        // Reset during the EXEC cycle of an ADD aborts it.
        c0 = cyc;
        set_op(FN_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(c0 + 2, "abort_exec", M_EN | M_ST | M_BUSY, M_EN | M_ST | M_BUSY | M_DONE);
        expect_at(c0 + 3, "abort_reset", 12'h000, M_ALL);
        for (int k = 4; k <= 6; k++)
            expect_at(c0 + k, $sformatf("abort_quiet_c%0d", k), 12'h000, M_OC | M_DONE | M_BUSY);
        tick(1);
        clear_op();
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(5);

        // Single-operand SHR without write-back.
        c0 = cyc;
        set_op(FN_SHR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(c0 + 1, "one_exec", op_bits(FN_SHR) | M_EN | M_BUSY | M_ST,
                  M_OP | M_EN | M_AC | M_BUSY | M_ST | M_DONE);
        expect_at(c0 + 2, "one_wb_nosout", op_bits(FN_SHR) | M_DONE | M_BUSY,
                  M_OP | M_EN | M_OC | M_ST | M_DONE | M_BUSY);
        tick(1);
        clear_op();
        tick(4);

        check("sb_drained", 12'(sb.size()), 12'h000);
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
